uart_alu_iface: RTL and testbench
=================================

# uart_alu_iface

Byte-level command sequencer sitting directly downstream of `uart_receiver` and upstream of the UART transmitter. It consumes received bytes, assembles a three-byte command (operand A, operand B, opcode), presents the command to the combinational ALU, captures the result and hands it to the transmitter as one byte. All control is one FSM plus operand/result registers; the ALU and transmitter are external.

## Interface
- `DATA_BITS`, 8: width of UART bytes, ALU operands and result.
- `OP_BITS`, 6: opcode width; taken from the LSBs of the opcode byte.
- `TIMEOUT_CYCLES`, 1_000_000: idle `i_clk` cycles before a partial command is discarded (used only with timeout compiled in).

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_done`  in  1  one-cycle pulse from receiver; byte valid that cycle.
- `i_rx_data`  in  DATA_BITS  received byte.
- `i_alu_result`  in  DATA_BITS  combinational ALU result.
- `o_alu_a`  out  DATA_BITS  operand A register.
- `o_alu_b`  out  DATA_BITS  operand B register.
- `o_alu_op`  out  OP_BITS  opcode register.
- `i_tx_done`  in  1  one-cycle pulse from transmitter: byte fully sent.
- `o_tx_start`  out  1  one-cycle request to transmitter.
- `o_tx_data`  out  DATA_BITS  result byte, held stable from `o_tx_start` until `i_tx_done`.
- `o_busy`  out  1  high in EXEC, SEND, WAIT_TX.
- `o_overrun`  out  1  one-cycle pulse when a byte arrives while busy.
- `o_timeout`  out  1  one-cycle pulse when a partial command is dropped.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on `i_rx_done`, load `o_alu_a` <= `i_rx_data`, go WAIT_B.
- WAIT_B: on `i_rx_done`, load `o_alu_b`, go WAIT_OP.
- WAIT_OP: on `i_rx_done`, load `o_alu_op` <= `i_rx_data[OP_BITS-1:0]` (upper bits ignored), go EXEC.
- EXEC: one cycle; `o_tx_data` <= `i_alu_result`; go SEND.
- SEND: `o_tx_start` = 1 for exactly this cycle; go WAIT_TX.
- WAIT_TX: on `i_tx_done`, go WAIT_A.
- `i_rx_done` in EXEC/SEND/WAIT_TX: byte dropped, `o_overrun` pulses same cycle, no register changes.
- `i_tx_done` outside WAIT_TX: ignored.
- Operand/opcode registers hold last values until overwritten; ALU inputs stay stable through transmission.
- No arithmetic performed in-block; widths pass through unchanged.

## Timing
- Reset values: `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data` = 0; `o_tx_start`, `o_busy`, `o_overrun`, `o_timeout` = 0.
- Registers load on the clock edge ending the `i_rx_done` cycle.
- Opcode `i_rx_done` at cycle N: EXEC at N+1, `o_tx_start` high at N+2, `o_tx_data` valid from N+2.
- `o_tx_start`, `o_overrun`, `o_timeout` are registered-state-derived/combinational pulses, never wider than one cycle.
- `i_reset` mid-command or mid-transmission: immediate return to WAIT_A, all outputs to reset values next edge; partial command lost.
- `i_reset` has priority over every other input in the same cycle.

## Configuration
- `UART_ALU_IFACE_TIMEOUT_EN` defined: cycle counter clears on every `i_rx_done` and on entry to WAIT_A; in WAIT_B or WAIT_OP, reaching `TIMEOUT_CYCLES-1` without `i_rx_done` returns to WAIT_A and pulses `o_timeout`. `i_rx_done` in the expiry cycle wins (byte accepted, no timeout). Counter inactive in WAIT_A, EXEC, SEND, WAIT_TX.
- Not defined: no counter; WAIT_B/WAIT_OP wait indefinitely; `o_timeout` tied 0.

## Structure
- Shared package `uart_alu_pkg`: state encoding constants, default `DATA_BITS`/`OP_BITS`, opcode constants (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRL 6'h02, SRA 6'h03) for bench and ALU.
- One sub-module: `uart_iface_timer` (clear, enable, expiry pulse), instantiated only under `UART_ALU_IFACE_TIMEOUT_EN`.

## Test plan
- Bytes 0x05, 0x03, 0x20 with bench ALU model -> `o_tx_start` one pulse 2 cycles after third `i_rx_done`, `o_tx_data` = 0x08, held until `i_tx_done`.
- Bytes 0x0F, 0xF0, 0xE2 -> `o_alu_op` = 6'h22, `o_tx_data` = 0x1F (SUB wrap).
- `i_rx_done` (0xAA) during WAIT_TX -> `o_overrun` pulse, `o_alu_a` unchanged, next command starts cleanly after `i_tx_done`.
- `i_reset` after second byte -> WAIT_A, `o_alu_a` = `o_alu_b` = 0; next three bytes form a fresh command.
- With `UART_ALU_IFACE_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16: one byte then 16 idle cycles -> `o_timeout` pulse, next byte loads `o_alu_a`.
- Without macro: one byte then 10,000 idle cycles -> still WAIT_B, `o_timeout` = 0; next two bytes complete the command.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the UART command sequencer, its ALU and its bench:
//   - default byte / opcode widths
//   - sequencer state encoding
//   - ALU opcode constants
//   - small state-classification helpers
// -----------------------------------------------------------------------------
package uart_alu_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int OP_BITS_DEF   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;

  // A command is being executed or its result transmitted.
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

  // A command has been started but is not yet complete.
  function automatic logic is_partial_state(input state_e s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/uart_iface_timer.sv
// -----------------------------------------------------------------------------
// uart_iface_timer
// Idle-cycle counter used to abandon partially received commands.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_clear         restart counting from zero this cycle
//   i_enable        count only while high; counter is held at zero otherwise
//   o_expire        high while enabled, not cleared, and TIMEOUT_CYCLES-1 reached
// -----------------------------------------------------------------------------
module uart_iface_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturate at the last value, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_enable) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the expiry cycle clears the counter and suppresses expiry.
  always_comb begin
    o_expire = i_enable && !i_clear && (cnt_q == LAST);
  end

endmodule

// File: rtl/uart_alu_iface.sv
// -----------------------------------------------------------------------------
// uart_alu_iface
// Collects three received bytes (operand A, operand B, opcode), presents them
// to an external combinational ALU, captures the result and hands it to the
// UART transmitter as a single byte.
// Optional feature: define UART_ALU_IFACE_TIMEOUT_EN to drop a partial command
// after TIMEOUT_CYCLES idle cycles (o_timeout pulses); otherwise o_timeout = 0.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rx_done, i_rx_data      received byte strobe and data
//   i_alu_result              combinational ALU result
//   o_alu_a, o_alu_b, o_alu_op  command registers driving the ALU
//   i_tx_done                 transmitter finished the byte
//   o_tx_start, o_tx_data     transmit request pulse and held result byte
//   o_busy                    executing or transmitting
//   o_overrun                 byte arrived while busy and was dropped
//   o_timeout                 partial command was dropped
// -----------------------------------------------------------------------------
module uart_alu_iface
  import uart_alu_pkg::*;
#(
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int OP_BITS        = OP_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [DATA_BITS-1:0] i_rx_data,
  input  logic [DATA_BITS-1:0] i_alu_result,
  output logic [DATA_BITS-1:0] o_alu_a,
  output logic [DATA_BITS-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_op,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic                 o_timeout
);

  state_e               state_q;
  state_e               state_d;
  logic [DATA_BITS-1:0] alu_a_q;
  logic [DATA_BITS-1:0] alu_b_q;
  logic [OP_BITS-1:0]   alu_op_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 partial_s;
  logic                 expire_s;

  assign partial_s = is_partial_state(state_q);

`ifdef UART_ALU_IFACE_TIMEOUT_EN
  uart_iface_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done),
    .i_enable (partial_s),
    .o_expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte in the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) state_d = ST_WAIT_B;
        else           state_d = ST_WAIT_A;
      end
      ST_WAIT_B: begin
        if (i_rx_done)     state_d = ST_WAIT_OP;
        else if (expire_s) state_d = ST_WAIT_A;
        else               state_d = ST_WAIT_B;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)     state_d = ST_EXEC;
        else if (expire_s) state_d = ST_WAIT_A;
        else               state_d = ST_WAIT_OP;
      end
      ST_EXEC: state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_d = ST_WAIT_A;
        else           state_d = ST_WAIT_TX;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  // Outputs derived from the current state and same-cycle strobes.
  always_comb begin
    o_busy     = is_busy_state(state_q);
    o_tx_start = (state_q == ST_SEND);
    o_overrun  = is_busy_state(state_q) && i_rx_done && !i_reset;
    o_timeout  = partial_s && expire_s && !i_rx_done && !i_reset;
  end

  // Command and result registers; bytes arriving while busy are not stored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_a_q   <= {DATA_BITS{1'b0}};
      alu_b_q   <= {DATA_BITS{1'b0}};
      alu_op_q  <= {OP_BITS{1'b0}};
      tx_data_q <= {DATA_BITS{1'b0}};
    end else begin
      if (i_rx_done && (state_q == ST_WAIT_A))  alu_a_q  <= i_rx_data;
      if (i_rx_done && (state_q == ST_WAIT_B))  alu_b_q  <= i_rx_data;
      if (i_rx_done && (state_q == ST_WAIT_OP)) alu_op_q <= i_rx_data[OP_BITS-1:0];
      if (state_q == ST_EXEC)                   tx_data_q <= i_alu_result;
    end
  end

  assign o_alu_a   = alu_a_q;
  assign o_alu_b   = alu_b_q;
  assign o_alu_op  = alu_op_q;
  assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_alu_iface.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_iface
// Directed bench for uart_alu_iface. A transaction-level model (bytes collected,
// cycles since a command completed, idle cycles) predicts every output each
// cycle; literal expectations pin the key results. Honours
// UART_ALU_IFACE_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_uart_alu_iface;
  import uart_alu_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_overrun;
  logic       o_timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  uart_alu_iface #(
    .DATA_BITS(8),
    .OP_BITS(6),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_alu_result (i_alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_timeout    (o_timeout)
  );

  // Bench ALU.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRL:  return a >> b[2:0];
      OP_SRA:  return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model state.
  logic [7:0] ma, mb, mtx;
  logic [5:0] mop;
  int nb, since, idle;
  bit busy_m, started;
  bit to_en;

  initial begin
    ma = 8'h00; mb = 8'h00; mtx = 8'h00; mop = 6'h00;
    nb = 0; since = 0; idle = 0; busy_m = 1'b0; started = 1'b0;
`ifdef UART_ALU_IFACE_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    forever begin
      @(posedge clk);
      if (i_reset) begin
        ma = 8'h00; mb = 8'h00; mtx = 8'h00; mop = 6'h00;
        nb = 0; since = 0; idle = 0; busy_m = 1'b0; started = 1'b1;
      end else if (busy_m) begin
        if (since == 1) mtx = alu_f(ma, mb, mop);
        if (since >= 3 && i_tx_done) busy_m = 1'b0;
        else since++;
      end else if (i_rx_done) begin
        if (nb == 0)      ma  = i_rx_data;
        else if (nb == 1) mb  = i_rx_data;
        else              mop = i_rx_data[5:0];
        if (nb == 2) begin
          nb = 0; busy_m = 1'b1; since = 1;
        end else begin
          nb++;
        end
        idle = 0;
      end else if (nb != 0) begin
        if (to_en && idle == TO - 1) begin
          nb = 0; idle = 0;
        end else begin
          idle++;
        end
      end
      @(negedge clk);
      if (started) begin
        chk("alu_a", 32'(o_alu_a), 32'(ma));
        chk("alu_b", 32'(o_alu_b), 32'(mb));
        chk("alu_op", 32'(o_alu_op), 32'(mop));
        chk("tx_data", 32'(o_tx_data), 32'(mtx));
        chk("busy", 32'(o_busy), 32'(busy_m));
        chk("tx_start", 32'(o_tx_start), 32'(busy_m && since == 2));
        chk("overrun", 32'(o_overrun), 32'(busy_m && i_rx_done && !i_reset));
        chk("timeout", 32'(o_timeout),
            32'(to_en && !busy_m && nb != 0 && idle == TO - 1 && !i_rx_done && !i_reset));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
    tick(); tick();
    chk("rst_a", 32'(o_alu_a), 32'h0);
    chk("rst_tx_data", 32'(o_tx_data), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_tx_start", 32'(o_tx_start), 32'h0);
    i_reset = 1'b0;
    tick();

    // ADD 5 + 3.
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    chk("exec_busy", 32'(o_busy), 32'h1);
    chk("exec_no_start", 32'(o_tx_start), 32'h0);
    tick();
    chk("add_start", 32'(o_tx_start), 32'h1);
    chk("add_result", 32'(o_tx_data), 32'h08);
    tick();
    chk("add_start_gone", 32'(o_tx_start), 32'h0);
    tick(); tick(); tick();
    chk("add_held", 32'(o_tx_data), 32'h08);
    tx_done_pulse();
    chk("add_idle", 32'(o_busy), 32'h0);

    // SUB with upper opcode bits set: 0x0F - 0xF0 wraps.
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hE2);
    tick();
    chk("sub_op", 32'(o_alu_op), 32'h22);
    chk("sub_result", 32'(o_tx_data), 32'h1F);
    tick();

    // Byte during WAIT_TX is dropped.
    i_rx_done = 1'b1; i_rx_data = 8'hAA;
    #1;
    chk("overrun_pulse", 32'(o_overrun), 32'h1);
    tick();
    i_rx_done = 1'b0;
    chk("overrun_a_kept", 32'(o_alu_a), 32'h0F);
    tick();
    tx_done_pulse();

    // Fresh command after overrun: OR 0x12 | 0x34.
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h25);
    tick();
    chk("or_result", 32'(o_tx_data), 32'h36);
    tick();
    tx_done_pulse();

    // tx_done while idle is ignored.
    tx_done_pulse();
    chk("stray_txdone", 32'(o_busy), 32'h0);

    // Reset after two bytes loses the partial command.
    send_byte(8'h11); send_byte(8'h22);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rst_mid_a", 32'(o_alu_a), 32'h0);
    chk("rst_mid_b", 32'(o_alu_b), 32'h0);
    send_byte(8'h40); send_byte(8'h04); send_byte(8'h02);
    tick();
    chk("srl_result", 32'(o_tx_data), 32'h04);
    chk("srl_a", 32'(o_alu_a), 32'h40);
    tick();
    tx_done_pulse();

`ifdef UART_ALU_IFACE_TIMEOUT_EN
    // One byte, then idle until the partial command expires.
    send_byte(8'h99);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("timeout_pulse", 32'(o_timeout), 32'h1);
    tick();
    chk("timeout_gone", 32'(o_timeout), 32'h0);
    send_byte(8'h77);
    chk("after_to_a", 32'(o_alu_a), 32'h77);
    send_byte(8'h01); send_byte(8'h26);
    tick();
    chk("after_to_xor", 32'(o_tx_data), 32'h76);
    tick();
    tx_done_pulse();
`else
    // One byte, then a long idle stretch: the command still completes.
    send_byte(8'h99);
    for (int i = 0; i < 10000; i++) tick();
    chk("no_timeout", 32'(o_timeout), 32'h0);
    chk("still_partial_a", 32'(o_alu_a), 32'h99);
    send_byte(8'h0F); send_byte(8'h24);
    tick();
    chk("late_and", 32'(o_tx_data), 32'h09);
    tick();
    tx_done_pulse();
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
